// File: rtl/imem_resp_if.sv
// Fetch request/response, redirect flush and program-load bundle for imem_resp.
// Latency: none (wiring only).
// Backpressure: req_ready/resp_ready valid-ready handshakes carried through.
interface imem_resp_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              flush;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_inst;
    logic [31:0]       resp_pc;
    logic              resp_err;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;

    // Fetch unit / loader side
    modport master (
        output req_valid, req_addr, flush, resp_ready, load_en, load_addr, load_data,
        input  req_ready, resp_valid, resp_inst, resp_pc, resp_err
    );

    // Instruction memory side
    modport slave (
        input  req_valid, req_addr, flush, resp_ready, load_en, load_addr, load_data,
        output req_ready, resp_valid, resp_inst, resp_pc, resp_err
    );
endinterface

// File: rtl/imem_resp.sv
// Instruction memory with a 1-cycle read stage feeding a 2-entry in-order response FIFO.
// Latency: request accepted at edge N -> resp_valid after edge N+1; no comb req->resp path.
// Backpressure: req_ready only when read stage + FIFO (minus a same-cycle pop) hold < 2.
module imem_resp #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst_n,
    imem_resp_if.slave  bus
);
    localparam int              DEPTH     = 1 << ADDR_W;
    // Range limits in 33 bits so a base near the top of the address space cannot wrap.
    localparam logic [32:0]     LO_BOUND  = {1'b0, BASE_ADDR};
    localparam logic [32:0]     HI_BOUND  = {1'b0, BASE_ADDR} + (33'd4 << ADDR_W);
    // BASE_ADDR is the byte address of word 0, so it is word aligned and the
    // word index can be formed from the address bits above the byte offset.
    localparam logic [ADDR_W-1:0] BASE_WORD = BASE_ADDR[ADDR_W+1:2];

    logic [31:0]       r_mem [DEPTH];

    logic              r_rs_vld;
    logic [31:0]       r_rs_raw;
    logic [31:0]       r_rs_pc;
    logic              r_rs_err;

    logic [31:0]       r_fifo_inst [2];
    logic [31:0]       r_fifo_pc   [2];
    logic [1:0]        r_fifo_err;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic              w_err;
    logic [ADDR_W-1:0] w_idx;
    logic              w_pop;
    logic              w_push;
    logic              w_accept;
    logic [2:0]        w_used;
    logic [31:0]       w_push_inst;

    assign w_err = (|bus.req_addr[1:0])
                || ({1'b0, bus.req_addr} <  LO_BOUND)
                || ({1'b0, bus.req_addr} >= HI_BOUND);
    assign w_idx = bus.req_addr[ADDR_W+1:2] - BASE_WORD;

    assign bus.resp_valid = (r_count != 2'd0);
    assign bus.resp_inst  = r_fifo_inst[r_rd_ptr];
    assign bus.resp_pc    = r_fifo_pc[r_rd_ptr];
    assign bus.resp_err   = r_fifo_err[r_rd_ptr];

    // A flush discards the FIFO, so a pop in the same cycle is ignored.
    assign w_pop    = bus.resp_valid && bus.resp_ready && !bus.flush;
    assign w_push   = r_rs_vld;
    // Slots committed after this edge; a same-cycle pop returns a credit.
    assign w_used   = 3'(r_count) + 3'(r_rs_vld) - 3'(w_pop);
    assign bus.req_ready = !bus.flush && (w_used < 3'd2);
    assign w_accept = bus.req_valid && bus.req_ready;
    // Faulting fetches return a NOP regardless of what the array holds.
    assign w_push_inst = r_rs_err ? 32'h00000000 : r_rs_raw;

    // Memory array and raw read data: not reset; read-before-write on a same-word load.
    always_ff @(posedge clk) begin
        if (bus.load_en) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
        if (w_accept) begin
            r_rs_raw <= r_mem[w_idx];
        end
    end

    // Read stage control: captures PC and fault status of the accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_vld <= 1'b0;
            r_rs_pc  <= 32'h0;
            r_rs_err <= 1'b0;
        end else if (bus.flush) begin
            r_rs_vld <= 1'b0;
        end else begin
            r_rs_vld <= w_accept;
            if (w_accept) begin
                r_rs_pc  <= bus.req_addr;
                r_rs_err <= w_err;
            end
        end
    end

    // Response FIFO: 2-entry circular buffer, 1-bit pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_inst[i] <= 32'h0;
                r_fifo_pc[i]   <= 32'h0;
            end
            r_fifo_err <= 2'b00;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else if (bus.flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_inst[r_wr_ptr] <= w_push_inst;
                r_fifo_pc[r_wr_ptr]   <= r_rs_pc;
                r_fifo_err[r_wr_ptr]  <= r_rs_err;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end
endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, log2 of instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h00400000, byte address of word 0.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  fetch request present.
REQ-006 SHALL have port req_ready  output  1  request can be accepted this cycle.
REQ-007 SHALL have port req_addr  input  32  fetch byte address (PC).
REQ-008 SHALL have port flush  input  1  discard all outstanding fetches (branch/redirect).
REQ-009 SHALL have port resp_valid  output  1  response present.
REQ-010 SHALL have port resp_ready  input  1  consumer takes response.
REQ-011 SHALL have port resp_inst  output  32  fetched instruction word.
REQ-012 SHALL have port resp_pc  output  32  address of the request this response answers.
REQ-013 SHALL have port resp_err  output  1  request was misaligned or out of range.
REQ-014 SHALL have port load_en  input  1  program-load write strobe.
REQ-015 SHALL have port load_addr  input  ADDR_W  word index to write.
REQ-016 SHALL have port load_data  input  32  word to write.

Function
REQ-017 Request accepted when req_valid && req_ready at a rising edge; response data is read from memory and enters a 2-entry response FIFO on the following edge.
REQ-018 Minimum latency: request accepted at edge N; resp_valid high after edge N+1 (1-cycle read stage plus FIFO); no combinational path req->resp.
REQ-019 Responses leave the FIFO strictly in acceptance order; resp_inst/resp_pc/resp_err reflect the FIFO head and hold stable while resp_valid && !resp_ready.
REQ-020 req_ready = !flush && (fifo_count + read_stage_valid) < 2; back-pressure never drops an accepted request.
REQ-021 A FIFO pop (resp_valid && resp_ready) in the same cycle frees a slot for the credit check of REQ-020 on that cycle.
REQ-022 Word index = (req_addr - BASE_ADDR) >> 2, truncated to ADDR_W bits after the range check.
REQ-023 Misaligned (req_addr[1:0] != 0) or out of range (req_addr < BASE_ADDR or req_addr >= BASE_ADDR + 4*2^ADDR_W) SHALL produce resp_err=1, resp_inst=32'h00000000 (NOP), resp_pc=req_addr.
REQ-024 Unsigned 32-bit comparison; the upper bound is computed in 33 bits so BASE_ADDR near 2^32 does not wrap.
REQ-025 flush at edge N clears the read stage and FIFO (count 0); resp_valid is low after edge N; a request presented during a flush cycle is not accepted (req_ready low).
REQ-026 flush and pop in the same cycle: flush wins; the pop is a don't-care.
REQ-027 load_en writes load_data to word load_addr at the edge; a read of the same word in the same cycle returns the old contents (read-before-write).
REQ-028 load_en is independent of the request handshake; it is legal with any pending fetch.
REQ-029 The FIFO is a 2-entry circular buffer with 1-bit read/write pointers that wrap modulo 2; count saturates at 2 by construction of REQ-020.

Reset
REQ-030 rst_n low asynchronously clears the read stage valid, FIFO count and pointers; resp_valid=0, resp_inst=0, resp_pc=0, resp_err=0; req_ready=1 once rst_n high and flush low.
REQ-031 Memory contents are not reset; reset asserted mid-transaction discards all outstanding fetches with no response.

Verification
REQ-032 Load word 5 = 32'h24080001, request 32'h00400014 with resp_ready=1 -> resp_valid next cycle, resp_inst=32'h24080001, resp_pc=32'h00400014, resp_err=0.
REQ-033 resp_ready=0, three back-to-back requests 0x00400000/04/08 -> two accepted, req_ready low on the third; after resp_ready=1, responses arrive in order and the third is accepted.
REQ-034 Request 32'h00400002 -> resp_err=1, resp_inst=0; request 32'h00401000 (ADDR_W=10) -> resp_err=1; request 32'h003FFFFC -> resp_err=1.
REQ-035 Two requests outstanding, flush pulsed one cycle -> resp_valid=0 the next cycle, no stale response ever appears, and the next request returns the correct word.
REQ-036 load_en to word 3 and fetch 32'h0040000C in the same cycle -> old word returned; repeat fetch -> new word.
REQ-037 rst_n dropped asynchronously between edges with two responses pending -> outputs 0 immediately; after release req_ready=1 and no response is emitted.
